// File: rtl/cdpga_pll_seq_pkg.sv
// Shared definitions for the PLL power-up/recovery sequencer: state encoding and widths.
package cdpga_pll_seq_pkg;

    localparam int unsigned ST_W    = 3;
    localparam int unsigned RETRY_W = 4;

    typedef enum logic [ST_W-1:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_e;

    // PLL is out of reset while waiting for, qualifying, or running on lock
    function automatic logic pll_released(input pll_state_e st);
        return (st == ST_WAIT_LOCK) || (st == ST_STABLE) || (st == ST_RUN);
    endfunction

endpackage

// File: rtl/cdpga_sync2.sv
// Generic two-flop synchronizer for a single asynchronous level, resets to 0.
module cdpga_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cdpga_pll_seq.sv
// PLL reset sequencer: timed PLL reset, lock wait with bounded retries,
// lock qualification, then core reset release and lock-loss recovery.
module cdpga_pll_seq
    import cdpga_pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 16000,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               restart,
    input  logic               pll_lock,
    output logic               pll_resetb,
    output logic               core_rst_n,
    output logic               locked,
    output logic               lock_lost,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    pll_state_e         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               lost_nxt;
    logic               lock_s;

    cdpga_sync2 u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_lock),
        .q       (lock_s)
    );

    // Next-state, counter and status; restart overrides every other transition
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        lost_nxt  = lock_lost;
        cnt_nxt   = cnt + CNT_W'(1);

        if (restart) begin
            state_nxt = ST_RST_PLL;
            retry_nxt = '0;
            lost_nxt  = 1'b0;
        end else begin
            case (state)
                ST_RST_PLL: begin
                    if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = ST_STABLE;
                    end else if (cnt == TO_LAST) begin
                        if (retry_cnt == RETRY_MAX) begin
                            state_nxt = ST_FAIL;
                        end else begin
                            state_nxt = ST_RST_PLL;
                            retry_nxt = retry_cnt + RETRY_W'(1);
                        end
                    end
                end
                ST_STABLE: begin
                    if (!lock_s)                  state_nxt = ST_WAIT_LOCK;
                    else if (cnt == STABLE_LAST)  state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_nxt = ST_RST_PLL;
                        lost_nxt  = 1'b1;
                        retry_nxt = '0;
                    end
                end
                ST_FAIL: ;
                default: state_nxt = ST_RST_PLL;
            endcase
        end

        // Counter only runs in timed states and restarts on every entry
        if (restart || (state_nxt != state) || (state == ST_RUN) || (state == ST_FAIL)) begin
            cnt_nxt = '0;
        end
    end

    // State, counter and registered outputs derived from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_RST_PLL;
            cnt        <= '0;
            retry_cnt  <= '0;
            lock_lost  <= 1'b0;
            pll_resetb <= 1'b0;
            core_rst_n <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            retry_cnt  <= retry_nxt;
            lock_lost  <= lost_nxt;
            pll_resetb <= pll_released(state_nxt);
            core_rst_n <= (state_nxt == ST_RUN);
            locked     <= (state_nxt == ST_RUN);
            fail       <= (state_nxt == ST_FAIL);
        end
    end

endmodule
